// File: rtl/calendar_pkg.sv
// rtl/calendar_pkg.sv - shared calendar constants, field codes and sequencer states
package calendar_pkg;

    localparam logic [5:0] JAN = 6'd0;
    localparam logic [5:0] FEB = 6'd1;
    localparam logic [5:0] MAR = 6'd2;
    localparam logic [5:0] APR = 6'd3;
    localparam logic [5:0] MAY = 6'd4;
    localparam logic [5:0] JUN = 6'd5;
    localparam logic [5:0] JUL = 6'd6;
    localparam logic [5:0] AUG = 6'd7;
    localparam logic [5:0] SEP = 6'd8;
    localparam logic [5:0] OCT = 6'd9;
    localparam logic [5:0] NOV = 6'd10;
    localparam logic [5:0] DEC = 6'd11;

    localparam logic [5:0] DAYS_IN_MONTH [12] = '{
        6'd31, 6'd28, 6'd31, 6'd30, 6'd31, 6'd30,
        6'd31, 6'd31, 6'd30, 6'd31, 6'd30, 6'd31
    };

    localparam logic [1:0] FLD_DAY   = 2'd0;
    localparam logic [1:0] FLD_MONTH = 2'd1;
    localparam logic [1:0] FLD_YEAR  = 2'd2;
    localparam logic [1:0] FLD_NONE  = 2'd3;

    typedef enum logic [1:0] {RUN, SET, CLAMP, APPLY} state_t;

endpackage

// File: rtl/calendar_month_len.sv
// rtl/calendar_month_len.sv - combinational month length lookup with leap February
module calendar_month_len
    import calendar_pkg::*;
(
    input  logic [5:0] month,
    input  logic       leap,
    output logic [5:0] dim
);

    always_comb begin
        dim = 6'd31;
        if (month < 6'd12) begin
            dim = DAYS_IN_MONTH[month[3:0]];
        end
        if (month == FEB && leap) begin
            dim = 6'd29;
        end
    end

endmodule

// File: rtl/calendar_sequencer.sv
// rtl/calendar_sequencer.sv - day/month/year registers with tick/edit arbitration
module calendar_sequencer
    import calendar_pkg::*;
#(
    parameter int YEAR_W      = 7,
    parameter int YEAR_MAX    = 99,
    parameter int RESET_DAY   = 1,
    parameter int RESET_MONTH = 0,
    parameter int RESET_YEAR  = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              day_tick,
    input  logic              set_mode,
    input  logic [1:0]        set_field,
    input  logic              set_inc,
    input  logic              set_dec,
    output logic [5:0]        day,
    output logic [5:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              month_increment,
    output logic              year_increment,
    output logic              day_reset,
    output logic              in_set,
    output logic              tick_lost
);

    localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);

    typedef struct packed {
        logic [5:0]        day;
        logic [5:0]        month;
        logic [YEAR_W-1:0] year;
        logic              day_reset;
        logic              month_inc;
        logic              year_inc;
    } tick_t;

    function automatic tick_t do_tick(input logic [5:0] d, input logic [5:0] m,
                                      input logic [YEAR_W-1:0] y, input logic [5:0] len);
        tick_t t;
        t.day       = d + 6'd1;
        t.month     = m;
        t.year      = y;
        t.day_reset = 1'b0;
        t.month_inc = 1'b0;
        t.year_inc  = 1'b0;
        if (d >= len) begin
            t.day       = 6'd1;
            t.day_reset = 1'b1;
            t.month_inc = 1'b1;
            if (m >= DEC) begin
                t.month    = JAN;
                t.year_inc = 1'b1;
                t.year     = (y >= YMAX) ? '0 : y + YEAR_W'(1);
            end else begin
                t.month = m + 6'd1;
            end
        end
        return t;
    endfunction

    state_t            state, state_n;
    logic              pending, pending_n, lost_n;
    logic [5:0]        day_n, month_n, dim;
    logic [YEAR_W-1:0] year_n;
    logic              dr_n, mi_n, yi_n;
    tick_t             tk;

    calendar_month_len u_month_len (
        .month (month),
        .leap  (year[1:0] == 2'b00),
        .dim   (dim)
    );

    always_comb begin
        tk        = do_tick(day, month, year, dim);
        state_n   = state;
        pending_n = pending;
        lost_n    = tick_lost;
        day_n     = day;
        month_n   = month;
        year_n    = year;
        dr_n      = 1'b0;
        mi_n      = 1'b0;
        yi_n      = 1'b0;

        // Ticks are banked while editing; a second one in the same session is lost.
        if (state != RUN && state != APPLY && day_tick) begin
            pending_n = 1'b1;
            if (pending) lost_n = 1'b1;
        end

        case (state)
            RUN: begin
                if (set_mode) begin
                    state_n   = SET;
                    pending_n = pending | day_tick;
                    if (pending && day_tick) lost_n = 1'b1;
                end else if (day_tick || pending) begin
                    {day_n, month_n, year_n, dr_n, mi_n, yi_n} = tk;
                    pending_n = pending & day_tick;
                end
            end
            SET: begin
                if (!set_mode) begin
                    state_n = (pending || day_tick) ? APPLY : RUN;
                end else if (set_inc ^ set_dec) begin
                    case (set_field)
                        FLD_DAY: begin
                            if (set_inc) day_n = (day >= dim) ? 6'd1 : day + 6'd1;
                            else         day_n = (day <= 6'd1) ? dim : day - 6'd1;
                        end
                        FLD_MONTH: begin
                            if (set_inc) month_n = (month >= DEC) ? JAN : month + 6'd1;
                            else         month_n = (month == JAN) ? DEC : month - 6'd1;
                            state_n = CLAMP;
                        end
                        FLD_YEAR: begin
                            if (set_inc) year_n = (year >= YMAX) ? '0 : year + YEAR_W'(1);
                            else         year_n = (year == '0) ? YMAX : year - YEAR_W'(1);
                            state_n = CLAMP;
                        end
                        default: ;
                    endcase
                end
            end
            CLAMP: begin
                if (day > dim) day_n = dim;
                state_n = SET;
            end
            APPLY: begin
                {day_n, month_n, year_n, dr_n, mi_n, yi_n} = tk;
                pending_n = day_tick;
                state_n   = RUN;
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= RUN;
            pending         <= 1'b0;
            tick_lost       <= 1'b0;
            day             <= 6'(RESET_DAY);
            month           <= 6'(RESET_MONTH);
            year            <= YEAR_W'(RESET_YEAR);
            day_reset       <= 1'b0;
            month_increment <= 1'b0;
            year_increment  <= 1'b0;
            in_set          <= 1'b0;
        end else begin
            state           <= state_n;
            pending         <= pending_n;
            tick_lost       <= lost_n;
            day             <= day_n;
            month           <= month_n;
            year            <= year_n;
            day_reset       <= dr_n;
            month_increment <= mi_n;
            year_increment  <= yi_n;
            in_set          <= (state_n == SET) || (state_n == CLAMP);
        end
    end

endmodule

// File: tb/tb_calendar_sequencer.sv
// tb/tb_calendar_sequencer.sv - directed table and sequence checks for calendar_sequencer
module tb_calendar_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       day_tick, set_mode, set_inc, set_dec;
    logic [1:0] set_field;
    logic [5:0] day, month;
    logic [6:0] year;
    logic       month_increment, year_increment, day_reset, in_set, tick_lost;

    int total = 0;
    int bad   = 0;

    calendar_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .day_tick        (day_tick),
        .set_mode        (set_mode),
        .set_field       (set_field),
        .set_inc         (set_inc),
        .set_dec         (set_dec),
        .day             (day),
        .month           (month),
        .year            (year),
        .month_increment (month_increment),
        .year_increment  (year_increment),
        .day_reset       (day_reset),
        .in_set          (in_set),
        .tick_lost       (tick_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sd, sm, sy;
        int ed, em, ey;
        int dr, mi, yi;
    } vec_t;

    vec_t vecs[8];

    function automatic int enc(input int d, input int m, input int y);
        return d * 10000 + m * 100 + y;
    endfunction

    function automatic int cur_date();
        return enc(int'(day), int'(month), int'(year));
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic edit(input logic [1:0] f, input logic inc);
        set_field = f;
        set_inc   = inc;
        set_dec   = ~inc;
        cyc();
        set_inc = 1'b0;
        set_dec = 1'b0;
        cyc();
    endtask

    task automatic set_date(input int d, input int m, input int y);
        set_mode = 1'b1;
        cyc();
        for (int i = 0; i < 128 && int'(year) != y; i++) edit(2'd2, 1'b1);
        for (int i = 0; i < 16 && int'(month) != m; i++) edit(2'd1, 1'b1);
        for (int i = 0; i < 40 && int'(day) != d; i++) edit(2'd0, 1'b1);
        set_field = 2'd3;
        set_mode  = 1'b0;
        cyc();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{sd:30, sm:3,  sy:18, ed:1,  em:4, ey:18, dr:1, mi:1, yi:0};
        vecs[1] = '{sd:31, sm:11, sy:99, ed:1,  em:0, ey:0,  dr:1, mi:1, yi:1};
        vecs[2] = '{sd:28, sm:1,  sy:20, ed:29, em:1, ey:20, dr:0, mi:0, yi:0};
        vecs[3] = '{sd:28, sm:1,  sy:19, ed:1,  em:2, ey:19, dr:1, mi:1, yi:0};
        vecs[4] = '{sd:29, sm:1,  sy:20, ed:1,  em:2, ey:20, dr:1, mi:1, yi:0};
        vecs[5] = '{sd:15, sm:5,  sy:5,  ed:16, em:5, ey:5,  dr:0, mi:0, yi:0};
        vecs[6] = '{sd:31, sm:11, sy:50, ed:1,  em:0, ey:51, dr:1, mi:1, yi:1};
        vecs[7] = '{sd:31, sm:0,  sy:18, ed:1,  em:1, ey:18, dr:1, mi:1, yi:0};

        reset = 1'b0; day_tick = 1'b0; set_mode = 1'b0;
        set_inc = 1'b0; set_dec = 1'b0; set_field = 2'd3;
        #13;
        chk("reset_date", cur_date(), enc(1, 0, 18));
        chk("reset_flags", {day_reset, month_increment, year_increment, in_set, tick_lost}, 0);
        reset = 1'b1;
        cyc();

        for (int i = 0; i < 8; i++) begin
            set_date(vecs[i].sd, vecs[i].sm, vecs[i].sy);
            chk($sformatf("vec%0d_setup", i), cur_date(), enc(vecs[i].sd, vecs[i].sm, vecs[i].sy));
            day_tick = 1'b1;
            cyc();
            day_tick = 1'b0;
            chk($sformatf("vec%0d_date", i), cur_date(), enc(vecs[i].ed, vecs[i].em, vecs[i].ey));
            chk($sformatf("vec%0d_pulses", i), {day_reset, month_increment, year_increment},
                vecs[i].dr * 4 + vecs[i].mi * 2 + vecs[i].yi);
            cyc();
            chk($sformatf("vec%0d_pulse_clear", i), {day_reset, month_increment, year_increment}, 0);
        end

        // Month edit lands on Feb 31 and CLAMP trims it to Feb 28
        set_date(31, 0, 18);
        set_mode = 1'b1;
        cyc();
        set_field = 2'd1; set_inc = 1'b1;
        cyc();
        set_inc = 1'b0;
        chk("clamp_pre", cur_date(), enc(31, 1, 18));
        chk("clamp_in_set", in_set, 1);
        chk("edit_no_pulse", {day_reset, month_increment, year_increment}, 0);
        cyc();
        chk("clamp_post", cur_date(), enc(28, 1, 18));
        set_field = 2'd0; set_inc = 1'b1;
        cyc();
        set_inc = 1'b0;
        chk("day_inc_wrap", int'(day), 1);
        set_dec = 1'b1;
        cyc();
        set_dec = 1'b0;
        chk("day_dec_wrap", int'(day), 28);
        set_mode = 1'b0;
        cyc();
        chk("exit_set", in_set, 0);

        // Tick deferred across a SET session, with overflow
        set_date(5, 2, 18);
        set_mode = 1'b1; day_tick = 1'b1;
        cyc();
        day_tick = 1'b0;
        chk("defer_date", cur_date(), enc(5, 2, 18));
        chk("defer_in_set", in_set, 1);
        for (int i = 0; i < 3; i++) begin
            day_tick = 1'b1;
            cyc();
            day_tick = 1'b0;
            cyc();
        end
        chk("tick_lost", tick_lost, 1);
        chk("defer_hold", int'(day), 5);
        set_mode = 1'b0;
        cyc();
        chk("apply_in_set", in_set, 0);
        chk("apply_pre", int'(day), 5);
        cyc();
        chk("apply_date", cur_date(), enc(6, 2, 18));
        chk("apply_no_pulse", {day_reset, month_increment, year_increment}, 0);

        // A tick landing in APPLY is applied by RUN on the following cycle
        set_mode = 1'b1;
        cyc();
        day_tick = 1'b1;
        cyc();
        day_tick = 1'b0; set_mode = 1'b0;
        cyc();
        day_tick = 1'b1;
        cyc();
        day_tick = 1'b0;
        chk("apply_tick_first", int'(day), 7);
        cyc();
        chk("apply_tick_second", int'(day), 8);

        // Asynchronous reset in the middle of CLAMP
        set_mode = 1'b1;
        cyc();
        set_field = 2'd1; set_inc = 1'b1;
        cyc();
        set_inc = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_clamp_date", cur_date(), enc(1, 0, 18));
        chk("rst_clamp_flags", {day_reset, month_increment, year_increment, in_set, tick_lost}, 0);
        #3;
        reset = 1'b1;
        set_mode = 1'b0; day_tick = 1'b1;
        cyc();
        day_tick = 1'b0;
        chk("post_rst_run", cur_date(), enc(2, 0, 18));
        chk("post_rst_in_set", in_set, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
